// File: rtl/nibbler_sequencer.sv
// nibbler_sequencer: multi-cycle FETCH/EXEC control sequencer for the Nibbler
// 4-bit CPU. Latches the opcode and holds the carry/zero flags. Decodes the
// 13-bit control word. Adds memory wait states with a timeout that leaves a
// sticky bus error, halt/resume, and a retired-instruction counter.
module nibbler_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic [12:0]      control,
  output logic             phase,
  output logic             halted,
  output logic             bus_error,
  output logic             flag_c,
  output logic             flag_z,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [12:0] CW_FETCH  = 13'h1008;
  localparam logic [12:0] CW_JUMP   = 13'h0808;
  localparam logic [12:0] CW_IDLE   = 13'h0000;
  // incPC, loadPC, loadA, loadFlags and loadOut must not fire while stalled.
  localparam logic [12:0] COMMIT_MASK = 13'h1E01;
  localparam logic [7:0]  WAIT_LAST   = 8'(WAIT_MAX - 1);

  state_t      state;
  logic [3:0]  ir;
  logic [7:0]  wait_cnt;
  logic [12:0] decoded;
  logic        stall;
  logic        timeout;

  // Opcode decode; jump conditions read the flag register before any update.
  always_comb begin
    // NOTE: a default on every path keeps this block from inferring a latch.
    decoded = CW_FETCH;
    case (ir)
      4'h0: decoded = flag_c ? CW_JUMP : CW_FETCH;
      4'h1: decoded = flag_c ? CW_FETCH : CW_JUMP;
      4'h2: decoded = 13'h0242;
      4'h3: decoded = 13'h1260;
      4'h4: decoded = 13'h0682;
      4'h5: decoded = 13'h0684;
      4'h6: decoded = 13'h16A0;
      4'h7: decoded = 13'h1038;
      4'h8: decoded = flag_z ? CW_JUMP : CW_FETCH;
      4'h9: decoded = flag_z ? CW_FETCH : CW_JUMP;
      4'hA: decoded = 13'h06C2;
      4'hB: decoded = 13'h16E0;
      4'hC: decoded = CW_JUMP;
      4'hD: decoded = 13'h0009;
      4'hE: decoded = 13'h0702;
      4'hF: decoded = 13'h1720;
      default: decoded = CW_FETCH;
    endcase
  end

  // Memory opcodes are exactly those with csRAM set; they stall until ready.
  assign stall   = (state == ST_EXEC) && decoded[5] && !mem_ready;
  assign timeout = stall && (wait_cnt == WAIT_LAST);

  // Control word per state; mem_ready reaches control combinationally.
  always_comb begin
    control = CW_FETCH;
    case (state)
      ST_FETCH: control = CW_FETCH;
      ST_EXEC:  control = stall ? (decoded & ~COMMIT_MASK) : decoded;
      ST_HALT:  control = CW_IDLE;
      default:  control = CW_FETCH;
    endcase
  end

  assign phase  = (state == ST_EXEC);
  assign halted = (state == ST_HALT);

  // Sequencer state, instruction latch, flags, wait counter, error, retire count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      ir          <= 4'h0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      wait_cnt    <= 8'd0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        ST_FETCH: begin
          ir    <= instr;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (timeout) begin
            bus_error <= 1'b1;
            wait_cnt  <= 8'd0;
            state     <= ST_HALT;
          end else if (stall) begin
            wait_cnt <= wait_cnt + 8'd1;
          end else begin
            if (decoded[9]) begin
              flag_c <= alu_c;
              flag_z <= alu_z;
            end
            instr_count <= instr_count + CNT_W'(1);
            wait_cnt    <= 8'd0;
            state       <= halt_req ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: begin
          if (!bus_error && !halt_req) state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer with WAIT_MAX=4 and CNT_W=2, so the
// timeout and the counter wrap are both reachable in a short run.
module tb_nibbler_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  instr;
  logic        alu_c;
  logic        alu_z;
  logic        mem_ready;
  logic        halt_req;
  logic [12:0] control;
  logic        phase;
  logic        halted;
  logic        bus_error;
  logic        flag_c;
  logic        flag_z;
  logic [1:0]  instr_count;

  int n_cmp = 0;
  int n_err = 0;

  nibbler_sequencer #(.WAIT_MAX(4), .CNT_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .control     (control),
    .phase       (phase),
    .halted      (halted),
    .bus_error   (bus_error),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then settle away from it.
  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; instr = 4'h0; alu_c = 1'b0; alu_z = 1'b0;
    mem_ready = 1'b1; halt_req = 1'b0;
    #1;
    check("rst_control", 32'(control), 32'h1008);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_flags", 32'({flag_c, flag_z}), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    tick; tick;
    reset = 1'b0;

    // ADDI sets carry.
    instr = 4'hA; alu_c = 1'b1; alu_z = 1'b0; #1;
    check("addi_fetch_cw", 32'(control), 32'h1008);
    check("addi_fetch_phase", 32'(phase), 32'd0);
    tick;
    check("addi_exec_cw", 32'(control), 32'h06C2);
    check("addi_exec_phase", 32'(phase), 32'd1);
    tick;
    check("addi_flag_c", 32'(flag_c), 32'd1);
    check("addi_flag_z", 32'(flag_z), 32'd0);
    check("addi_count", 32'(instr_count), 32'd1);
    check("addi_next_fetch", 32'(control), 32'h1008);

    // CMPI sets zero, clears carry.
    instr = 4'h2; alu_c = 1'b0; alu_z = 1'b1;
    tick;
    check("cmpi_exec_cw", 32'(control), 32'h0242);
    tick;
    check("cmpi_flags", 32'({flag_c, flag_z}), 32'b01);
    check("cmpi_count", 32'(instr_count), 32'd2);

    // Conditional jumps with Z=1, C=0; alu inputs flipped to prove no flag load.
    alu_c = 1'b1; alu_z = 1'b0;
    instr = 4'h8; tick;
    check("jz_taken", 32'(control), 32'h0808);
    tick;
    instr = 4'h9; tick;
    check("jnz_not_taken", 32'(control), 32'h1008);
    tick;
    check("count_wrap", 32'(instr_count), 32'd0);
    instr = 4'h0; tick;
    check("jc_not_taken", 32'(control), 32'h1008);
    tick;
    instr = 4'h1; tick;
    check("jnc_taken", 32'(control), 32'h0808);
    tick;
    check("jumps_keep_flags", 32'({flag_c, flag_z}), 32'b01);
    check("jumps_count", 32'(instr_count), 32'd2);

    // LD with three not-ready cycles, then ready.
    instr = 4'h6; mem_ready = 1'b0; alu_c = 1'b0; alu_z = 1'b1;
    tick;
    check("ld_wait1_cw", 32'(control), 32'h00A0);
    check("ld_wait1_phase", 32'(phase), 32'd1);
    tick;
    check("ld_wait2_cw", 32'(control), 32'h00A0);
    tick;
    check("ld_wait3_cw", 32'(control), 32'h00A0);
    mem_ready = 1'b1; #1;
    check("ld_commit_cw", 32'(control), 32'h16A0);
    tick;
    check("ld_back_fetch", 32'(phase), 32'd0);
    check("ld_count", 32'(instr_count), 32'd3);

    // halt_req raised during FETCH of OUT.
    instr = 4'hD; halt_req = 1'b1;
    tick;
    check("out_exec_cw", 32'(control), 32'h0009);
    check("out_exec_halted", 32'(halted), 32'd0);
    tick;
    check("halt_cw", 32'(control), 32'h0000);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_phase", 32'(phase), 32'd0);
    check("out_count_wrap", 32'(instr_count), 32'd0);
    tick;
    check("halt_held", 32'(halted), 32'd1);
    halt_req = 1'b0;
    tick;
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_cw", 32'(control), 32'h1008);

    // ADDI to make state non-zero, then reset mid-wait on ADDM.
    instr = 4'hA; alu_c = 1'b1; alu_z = 1'b0;
    tick; tick;
    check("pre_rst_count", 32'(instr_count), 32'd1);
    instr = 4'hB; mem_ready = 1'b0;
    tick;
    check("addm_wait_cw", 32'(control), 32'h00E0);
    tick;
    reset = 1'b1; #1;
    check("midrst_cw", 32'(control), 32'h1008);
    check("midrst_phase", 32'(phase), 32'd0);
    check("midrst_flags", 32'({flag_c, flag_z}), 32'd0);
    check("midrst_count", 32'(instr_count), 32'd0);
    check("midrst_bus_error", 32'(bus_error), 32'd0);
    tick;
    reset = 1'b0; mem_ready = 1'b1;

    // JMP commits once, then ST times out after 4 not-ready cycles.
    instr = 4'hC; tick;
    check("jmp_cw", 32'(control), 32'h0808);
    tick;
    instr = 4'h7; mem_ready = 1'b0;
    tick;
    check("st_wait_cw", 32'(control), 32'h0038);
    tick; tick; tick;
    check("st_wait4_phase", 32'(phase), 32'd1);
    check("st_wait4_err", 32'(bus_error), 32'd0);
    tick;
    check("to_bus_error", 32'(bus_error), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_cw", 32'(control), 32'h0000);
    check("to_count_kept", 32'(instr_count), 32'd1);
    mem_ready = 1'b1;
    tick; tick; tick;
    check("to_stuck_halted", 32'(halted), 32'd1);
    check("to_stuck_err", 32'(bus_error), 32'd1);
    reset = 1'b1; #1;
    check("to_rst_err", 32'(bus_error), 32'd0);
    check("to_rst_halted", 32'(halted), 32'd0);
    tick;
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
